// File: rtl/operand_fetch_ctrl_if.sv
// Bundle of the request, register-file, operand and writeback signals of operand_fetch_ctrl.
// master = the sequencer itself, slave = the surrounding decode/regfile/execute environment.
interface operand_fetch_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_srcA;
  logic [ADDR_W-1:0] req_srcB;
  logic [ADDR_W-1:0] req_dst;
  logic              req_wb;
  logic [ADDR_W-1:0] rf_rdAddrA;
  logic [ADDR_W-1:0] rf_rdAddrB;
  logic              rf_regdst;
  logic [DATA_W-1:0] rf_rdData;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [ADDR_W-1:0] op_dst;
  logic              op_wb;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_wrAddr;
  logic [DATA_W-1:0] rf_wrData;

  modport master (
    input  req_valid, req_srcA, req_srcB, req_dst, req_wb, rf_rdData,
           op_ready, wb_valid, wb_addr, wb_data,
    output req_ready, rf_rdAddrA, rf_rdAddrB, rf_regdst, op_valid,
           opA, opB, op_dst, op_wb, rf_write, rf_wrAddr, rf_wrData
  );

  modport slave (
    output req_valid, req_srcA, req_srcB, req_dst, req_wb, rf_rdData,
           op_ready, wb_valid, wb_addr, wb_data,
    input  req_ready, rf_rdAddrA, rf_rdAddrB, rf_regdst, op_valid,
           opA, opB, op_dst, op_wb, rf_write, rf_wrAddr, rf_wrData
  );
endinterface

// File: rtl/operand_fetch_ctrl.sv
// Two-cycle operand fetch sequencer with writeback scoreboard and RAW/WAW stalls.
// Optional same-cycle writeback forwarding is enabled by defining OFC_BYPASS_EN.
module operand_fetch_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  operand_fetch_ctrl_if.master bus
);

  localparam int NREG = 1 << ADDR_W;

`ifdef OFC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, OUT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d;
  logic [ADDR_W-1:0] src_b_q, src_b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
  logic              regdst_q, regdst_d;
  logic              req_ready_q, req_ready_d;
  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic hit_a, hit_b, hit_dst;
  logic fwd_a, fwd_b, fwd_dst;
  logic set_en;

  // Forwarding only applies to a source that is actually pending.
  always_comb begin
    hit_a   = pending_q[src_a_q];
    hit_b   = pending_q[src_b_q];
    hit_dst = pending_q[dst_q];
    fwd_a   = BYPASS && bus.wb_valid && (bus.wb_addr == src_a_q) && hit_a;
    fwd_b   = BYPASS && bus.wb_valid && (bus.wb_addr == src_b_q) && hit_b;
    fwd_dst = BYPASS && bus.wb_valid && (bus.wb_addr == dst_q) && hit_dst;
  end

  always_comb begin
    state_d     = state_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dst_d       = dst_q;
    wb_d        = wb_q;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    regdst_d    = regdst_q;
    req_ready_d = req_ready_q;
    op_valid_d  = op_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    set_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          src_a_d     = bus.req_srcA;
          src_b_d     = bus.req_srcB;
          dst_d       = bus.req_dst;
          wb_d        = bus.req_wb;
          rd_addr_a_d = bus.req_srcA;
          regdst_d    = 1'b0;
          req_ready_d = 1'b0;
          state_d     = RD_A;
        end
      end
      RD_A: begin
        if (!hit_a || fwd_a) begin
          op_a_d      = fwd_a ? bus.wb_data : bus.rf_rdData;
          rd_addr_b_d = src_b_q;
          regdst_d    = 1'b1;
          state_d     = RD_B;
        end
      end
      RD_B: begin
        // Hold for a pending source B, or for our own destination still awaiting an older writeback.
        if (!((hit_b && !fwd_b) || (wb_q && hit_dst && !fwd_dst))) begin
          op_b_d     = fwd_b ? bus.wb_data : bus.rf_rdData;
          set_en     = wb_q;
          op_valid_d = 1'b1;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (bus.op_ready) begin
          op_valid_d  = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear before set so that a same-cycle set on the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (bus.wb_valid) pending_d[bus.wb_addr] = 1'b0;
    if (set_en)       pending_d[dst_q]       = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_a_q     <= '0;
      src_b_q     <= '0;
      dst_q       <= '0;
      wb_q        <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      regdst_q    <= 1'b0;
      req_ready_q <= 1'b1;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dst_q       <= dst_d;
      wb_q        <= wb_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      regdst_q    <= regdst_d;
      req_ready_q <= req_ready_d;
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rf_rdAddrA = rd_addr_a_q;
  assign bus.rf_rdAddrB = rd_addr_b_q;
  assign bus.rf_regdst  = regdst_q;
  assign bus.op_valid   = op_valid_q;
  assign bus.opA        = op_a_q;
  assign bus.opB        = op_b_q;
  assign bus.op_dst     = dst_q;
  assign bus.op_wb      = wb_q;
  assign bus.rf_write   = bus.wb_valid & ~rst;
  assign bus.rf_wrAddr  = bus.wb_addr;
  assign bus.rf_wrData  = bus.wb_data;

endmodule
